lsu_wb_master: RTL and testbench

Load/store unit bus front-end: accepts one load or store at a time from the core's memory stage and runs it as a classic Wishbone cycle toward the data interconnect and the byte-laned BRAM slave. It generates byte selects, places store data, rejects misaligned accesses, and sign- or zero-extends returned load data. It sits directly upstream of the data-memory slaves.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_load_extend.sv | 25 ++
 rtl/lsu_wb_master.sv | 163 ++++++++++++++++
 tb/tb_lsu_wb_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the load/store unit
// Wishbone front-end.
//   lsu_size_t   : access width (BYTE/HALF/WORD); encoding 2'b11 is illegal
//   lsu_state_t  : bus-cycle state, with ST_* constants
//   SEL_*        : byte-select patterns for right-aligned accesses
//   is_misaligned, size_to_sel, place_wdata : request decode helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_t;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_BUS  = 2'd1;  // cyc=1, stb=1
  localparam lsu_state_t ST_WAIT = 2'd2;  // cyc=1, stb=0, waiting for ack/err
  localparam lsu_state_t ST_RESP = 2'd3;  // completion pulse cycle

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Takes the raw size field so that the illegal encoding is rejected too.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] size_to_sel(input lsu_size_t size);
    logic [3:0] sel;
    case (size)
      BYTE:    sel = SEL_BYTE;
      HALF:    sel = SEL_HALF;
      default: sel = SEL_WORD;
    endcase
    return sel;
  endfunction

  // Store data is kept right-aligned; unused upper lanes are driven to zero.
  function automatic logic [31:0] place_wdata(input lsu_size_t size,
                                              input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      BYTE:    d = {24'b0, wdata[7:0]};
      HALF:    d = {16'b0, wdata[15:0]};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: combinational sign/zero extension of returned load data.
// The slave returns the addressed lanes already shifted into the low bits.
//   data        in  32 : captured slave data
//   size        in     : access width
//   is_unsigned in  1  : zero-extend instead of sign-extend
//   ext         out 32 : extended result
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      BYTE:    ext = {{24{~is_unsigned & data[7]}}, data[7:0]};
      HALF:    ext = {{16{~is_unsigned & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: runs one core load/store at a time as a classic Wishbone
// cycle. Generates byte selects, places store data, rejects misaligned
// requests without touching the bus, and extends returned load data.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus cycle that has not
// been answered within TIMEOUT_CYCLES cycles (reported as a bus error).
//
// Ports
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata/
//   i_size/i_unsigned               : core request (sampled only when idle)
//   o_busy                          : request in flight
//   o_valid, o_rdata                : completion pulse, extended load data
//   o_misalign                      : request rejected, no bus cycle
//   o_bus_err                       : completion with error / timeout
//   o_cyc/o_stb/o_we/o_addr/
//   o_data/o_sel                    : Wishbone master outputs (registered)
//   i_ack/i_err/i_stall/i_data      : Wishbone slave responses
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_busy,
  output logic              o_valid,
  output logic [31:0]       o_rdata,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_cyc,
  output logic              o_stb,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_data,
  output logic [3:0]        o_sel,
  input  logic              i_ack,
  input  logic              i_err,
  input  logic              i_stall,
  input  logic [31:0]       i_data
);

  lsu_state_t  state;
  lsu_size_t   size_reg;
  logic        unsigned_reg;
  logic [31:0] data_reg;
  logic [31:0] ext_data;
  logic        in_cycle;
  logic        bus_resp;
  logic        timeout_hit;

  assign in_cycle = (state == ST_BUS) || (state == ST_WAIT);

  // A stalled strobe has not been accepted, so a response then is ignored.
  assign bus_resp = (((state == ST_BUS) && !i_stall) || (state == ST_WAIT)) &&
                    (i_ack || i_err);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] tcnt;

  // Counter holds (cycles spent in this bus cycle - 1); cleared outside it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt <= '0;
    end else if (in_cycle) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign timeout_hit = in_cycle && (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      size_reg     <= BYTE;
      unsigned_reg <= 1'b0;
      data_reg     <= '0;
      o_valid      <= 1'b0;
      o_misalign   <= 1'b0;
      o_bus_err    <= 1'b0;
      o_cyc        <= 1'b0;
      o_stb        <= 1'b0;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_sel        <= '0;
    end else begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            if (is_misaligned(i_size, i_addr[1:0])) begin
              o_misalign <= 1'b1;
            end else begin
              state        <= ST_BUS;
              o_cyc        <= 1'b1;
              o_stb        <= 1'b1;
              o_we         <= i_we;
              o_addr       <= i_addr;
              o_sel        <= size_to_sel(lsu_size_t'(i_size));
              o_data       <= place_wdata(lsu_size_t'(i_size), i_wdata);
              size_reg     <= lsu_size_t'(i_size);
              unsigned_reg <= i_unsigned;
            end
          end
        end
        ST_BUS, ST_WAIT: begin
          if (bus_resp) begin
            // err wins when ack and err arrive together
            state <= ST_RESP;
            o_cyc <= 1'b0;
            o_stb <= 1'b0;
            if (i_err) begin
              o_bus_err <= 1'b1;
            end else begin
              o_valid  <= 1'b1;
              data_reg <= i_data;
            end
          end else if (timeout_hit) begin
            state     <= ST_RESP;
            o_cyc     <= 1'b0;
            o_stb     <= 1'b0;
            o_bus_err <= 1'b1;
          end else if ((state == ST_BUS) && !i_stall) begin
            state <= ST_WAIT;
            o_stb <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  lsu_load_extend u_extend (
    .data        (data_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .ext         (ext_data)
  );

  // Only a successful load presents data; stores and errors read as zero.
  assign o_rdata = (o_valid && !o_we) ? ext_data : 32'h0;
  assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: directed bench for lsu_wb_master. A transaction-level
// model expands each request into its expected per-cycle output timeline;
// a compare process checks the DUT against that timeline every cycle.
// Define LSU_TIMEOUT_EN to also exercise the bus timeout (TIMEOUT_CYCLES=4).
module tb_lsu_wb_master;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        req, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, valid, mis, berr;
  logic [31:0] rdata;
  logic        cyc, stb, owe;
  logic [31:0] oaddr, odata;
  logic [3:0]  osel;
  logic        ack, err, stall;
  logic [31:0] idata;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  lsu_wb_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_size(size), .i_unsigned(uns),
    .o_busy(busy), .o_valid(valid), .o_rdata(rdata),
    .o_misalign(mis), .o_bus_err(berr),
    .o_cyc(cyc), .o_stb(stb), .o_we(owe), .o_addr(oaddr),
    .o_data(odata), .o_sel(osel),
    .i_ack(ack), .i_err(err), .i_stall(stall), .i_data(idata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          cyc, stb, busy, valid, berr, mis;
    bit          chk_rd;
    logic [31:0] rdata;
    bit          bus;
    bit          chk_data;
    bit          we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tot_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a & ((32'h1 << sz) - 1)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz);
    return 4'((32'h1 << (1 << sz)) - 1);
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd2) return w;
    return w & ((32'h1 << (8 << sz)) - 1);
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] sz, input bit u);
    int nb;
    logic [31:0] mask, r;
    if (sz == 2'd2) return d;
    nb   = 8 << sz;
    mask = (32'h1 << nb) - 1;
    r    = d & mask;
    if (!u && d[nb-1]) r = r | ~mask;
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc", cyc, e.cyc);
      chk("stb", stb, e.stb);
      chk("busy", busy, e.busy);
      chk("valid", valid, e.valid);
      chk("bus_err", berr, e.berr);
      chk("misalign", mis, e.mis);
      if (e.chk_rd) chk("rdata", rdata, e.rdata);
      if (e.bus) begin
        chk("o_addr", oaddr, e.addr);
        chk("o_sel", osel, e.sel);
        chk("o_we", owe, e.we);
        if (e.chk_data) chk("o_data", odata, e.data);
      end
    end
  end

  // Runs one request starting in the current cycle (called at posedge+2).
  // S = stalled cycles, W = WAIT cycles before the response (0 = ack in BUS).
  task automatic run_txn(input bit t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [1:0] t_size, input bit t_uns, input int S, input int W,
                         input bit t_err, input logic [31:0] t_rsp, input bit hold_req,
                         output logic [31:0] got_rdata, output int got_vk,
                         output logic [3:0] got_sel, output logic [31:0] got_data,
                         output logic [31:0] got_addr);
    bit misal;
    int a, last;
    exp_t e;
    misal = m_mis(t_addr, t_size);
    a     = S + 1 + W;
    last  = misal ? 1 : a + 1;
    chk("idle_busy", busy, 0);
    chk("idle_cyc", cyc, 0);
    for (int k = 1; k <= last; k++) begin
      e = '{default: 0};
      if (misal) begin
        e.mis = 1'b1;
      end else if (k <= a) begin
        e.cyc  = 1'b1;
        e.busy = 1'b1;
        if (k <= S + 1) begin
          e.stb = 1'b1; e.bus = 1'b1; e.we = t_we; e.addr = t_addr;
          e.sel = m_sel(t_size); e.data = m_data(t_wdata, t_size); e.chk_data = t_we;
        end
      end else begin
        e.busy   = 1'b1;
        e.valid  = !t_err;
        e.berr   = t_err;
        e.chk_rd = !t_err;
        e.rdata  = t_we ? 32'h0 : m_ext(t_rsp, t_size, t_uns);
      end
      exp_q.push_back(e);
    end
    got_vk = -1; got_rdata = '0; got_sel = '0; got_data = '0; got_addr = '0;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) begin
        we = t_we; addr = t_addr; wdata = t_wdata; size = t_size; uns = t_uns;
      end
      req   = (k == 0) || (hold_req && !misal);
      stall = !misal && (k >= 1) && (k <= S);
      ack   = !misal && (k == a) && !t_err;
      err   = !misal && (k == a) && t_err;
      idata = (k == a) ? t_rsp : 32'hDEADBEEF;
      if (k == 1 && !misal) begin
        got_sel = osel; got_data = odata; got_addr = oaddr;
      end
      if (valid) begin
        got_vk = k; got_rdata = rdata;
      end
      @(posedge clk); #2;
    end
    req = 0; ack = 0; err = 0; stall = 0;
    $display("txn we=%0d addr=%h size=%0d uns=%0d stall=%0d wait=%0d err=%0d -> valid_cycle=%0d rdata=%h",
             t_we, t_addr, t_size, t_uns, S, W, t_err, got_vk, got_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, d, ad;
    logic [3:0]  s;
    int vk;
    rst_n = 0; req = 0; we = 0; uns = 0; addr = 0; wdata = 0; size = 0;
    ack = 0; err = 0; stall = 0; idata = 0;
    #3;
    chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0); chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0); chk("rst_sel", osel, 0); chk("rst_addr", oaddr, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #2;

    // LB signed / LBU
    run_txn(0, 32'h20000003, 0, 2'd0, 0, 0, 1, 0, 32'h00000080, 0, r, vk, s, d, ad);
    chk("lb_rdata", r, 32'hFFFFFF80); chk("lb_sel", s, 4'b0001); chk("lb_valid_cycle", vk, 3);
    run_txn(0, 32'h20000003, 0, 2'd0, 1, 0, 1, 0, 32'h00000080, 0, r, vk, s, d, ad);
    chk("lbu_rdata", r, 32'h00000080);
    // SH
    run_txn(1, 32'h20000002, 32'h1234ABCD, 2'd1, 0, 0, 1, 0, 32'h55555555, 0, r, vk, s, d, ad);
    chk("sh_sel", s, 4'b0011); chk("sh_addr", ad, 32'h20000002);
    chk("sh_data", d, 32'h0000ABCD); chk("sh_rdata", r, 32'h0);
    // misaligned requests
    run_txn(0, 32'h20000006, 0, 2'd2, 0, 0, 1, 0, 0, 0, r, vk, s, d, ad);
    chk("misal_no_valid", vk, -1);
    run_txn(0, 32'h00000101, 0, 2'd1, 0, 0, 1, 0, 0, 0, r, vk, s, d, ad);
    run_txn(1, 32'h00000100, 32'h1, 2'd3, 0, 0, 1, 0, 0, 0, r, vk, s, d, ad);
    // LW with 3 stall cycles
    run_txn(0, 32'h20000010, 0, 2'd2, 0, 3, 1, 0, 32'hCAFEF00D, 0, r, vk, s, d, ad);
    chk("stall_valid_cycle", vk, 6); chk("stall_rdata", r, 32'hCAFEF00D);
    // half loads, ack during BUS, longer WAIT
    run_txn(0, 32'h00000102, 0, 2'd1, 0, 0, 0, 0, 32'h00008001, 0, r, vk, s, d, ad);
    chk("lh_rdata", r, 32'hFFFF8001); chk("ack_in_bus_cycle", vk, 2);
    run_txn(0, 32'h00000102, 0, 2'd1, 1, 1, 3, 0, 32'h0000F00F, 0, r, vk, s, d, ad);
    chk("lhu_rdata", r, 32'h0000F00F);
    // SB, SW with request held high while busy
    run_txn(1, 32'h00000203, 32'hA5A5A57E, 2'd0, 0, 2, 2, 0, 0, 0, r, vk, s, d, ad);
    run_txn(1, 32'h00000204, 32'h89ABCDEF, 2'd2, 0, 0, 1, 0, 0, 1, r, vk, s, d, ad);
    // error in WAIT
    run_txn(0, 32'h00000300, 0, 2'd2, 0, 0, 2, 1, 32'h12345678, 0, r, vk, s, d, ad);
    chk("err_no_valid", vk, -1);
    run_txn(0, 32'h00000304, 0, 2'd2, 0, 0, 1, 0, 32'h0BADF00D, 0, r, vk, s, d, ad);

    // asynchronous reset in WAIT, then in a stalled BUS cycle
    req = 1; we = 0; addr = 32'h40; size = 2'd2; uns = 0;
    @(posedge clk); #2; req = 0;
    @(posedge clk); #2;
    chk("wait_cyc", cyc, 1); chk("wait_stb", stb, 0);
    #1 rst_n = 0;
    #1 chk("arst_cyc", cyc, 0); chk("arst_stb", stb, 0); chk("arst_busy", busy, 0);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #2;
    req = 1; stall = 1;
    @(posedge clk); #2; req = 0;
    chk("bus_stb", stb, 1);
    #1 rst_n = 0;
    #1 chk("arst_bus_stb", stb, 0); chk("arst_bus_cyc", cyc, 0);
    stall = 0;
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #2;
    run_txn(0, 32'h00000040, 0, 2'd2, 0, 0, 1, 0, 32'h600DCAFE, 0, r, vk, s, d, ad);
    chk("post_rst_rdata", r, 32'h600DCAFE);

`ifdef LSU_TIMEOUT_EN
    begin
      exp_t e;
      for (int k = 1; k <= 7; k++) begin
        e = '{default: 0};
        if (k <= 4) begin e.cyc = 1; e.busy = 1; end
        if (k == 1) begin e.stb = 1; e.bus = 1; e.addr = 32'h80; e.sel = 4'b1111; end
        if (k == 5) begin e.busy = 1; e.berr = 1; e.chk_rd = 1; e.rdata = 0; end
        exp_q.push_back(e);
      end
      for (int k = 0; k <= 7; k++) begin
        req = (k == 0); we = 0; addr = 32'h80; size = 2'd2;
        ack = (k == 5) || (k == 6);
        idata = 32'h77777777;
        @(posedge clk); #2;
      end
      ack = 0;
      $display("txn timeout addr=00000080 late ack injected");
    end
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
